// File: rtl/pwm_deadtime_pkg.sv
// Shared types and constants for the dead-time inserting gate driver.
package pwm_deadtime_pkg;

    localparam int DTW_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DT_TO_HI = 3'd1,
        ST_HI_ON    = 3'd2,
        ST_DT_TO_LO = 3'd3,
        ST_LO_ON    = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    function automatic logic is_dt_state(input state_e s);
        return (s == ST_DT_TO_HI) || (s == ST_DT_TO_LO);
    endfunction

endpackage

// File: rtl/pwm_dt_timer.sv
// Loadable down-counter timing one dead-time interval; done flags its last cycle.
module pwm_dt_timer
    import pwm_deadtime_pkg::*;
#(
    parameter int DTW = DTW_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_i,
    input  logic [DTW-1:0] load_val_i,
    input  logic           en_i,
    output logic           done_o
);

    logic [DTW-1:0] count_q;
    logic [DTW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - DTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of 1 means the interval ends on the coming edge.
    assign done_o = (count_q <= DTW'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate driver: inserts a programmable dead time between high and
// low side conduction and latches a fault state with both gates off.
module pwm_deadtime
    import pwm_deadtime_pkg::*;
#(
    parameter int DTW = DTW_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pwm_in,
    input  logic [DTW-1:0] dt_cfg,
    input  logic           fault,
    input  logic           fault_clr,
    output logic           gate_hi,
    output logic           gate_lo,
    output logic           dt_active,
    output logic           fault_latched
);

    state_e         state_q;
    state_e         state_d;
    logic           pwm_s_q;
    logic           pwm_vld_q;
    logic           gate_hi_q;
    logic           gate_hi_d;
    logic           gate_lo_q;
    logic           gate_lo_d;
    logic           dt_active_q;
    logic           dt_active_d;
    logic           fault_latched_q;
    logic           fault_latched_d;
    logic           dt_done;
    logic           timer_load;
    logic           timer_en;
    logic [DTW-1:0] dt_load_val;

    // A zero setting still guarantees one cycle with both gates off.
    assign dt_load_val = (dt_cfg == '0) ? DTW'(1) : dt_cfg;
    assign timer_load  = is_dt_state(state_d) && (state_d != state_q);
    assign timer_en    = is_dt_state(state_q) && (state_d == state_q);

    pwm_dt_timer #(
        .DTW (DTW)
    ) u_dt_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (dt_load_val),
        .en_i       (timer_en),
        .done_o     (dt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            pwm_s_q         <= 1'b0;
            pwm_vld_q       <= 1'b0;
            gate_hi_q       <= 1'b0;
            gate_lo_q       <= 1'b0;
            dt_active_q     <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pwm_s_q         <= pwm_in;
            pwm_vld_q       <= 1'b1;
            gate_hi_q       <= gate_hi_d;
            gate_lo_q       <= gate_lo_d;
            dt_active_q     <= dt_active_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                // Wait until pwm_s holds a real sample before picking a direction.
                ST_IDLE: begin
                    if (pwm_vld_q) begin
                        state_d = pwm_s_q ? ST_DT_TO_HI : ST_DT_TO_LO;
                    end
                end
                ST_DT_TO_HI: begin
                    if (!pwm_s_q) begin
                        state_d = ST_LO_ON;
                    end else if (dt_done) begin
                        state_d = ST_HI_ON;
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_s_q) begin
                        state_d = ST_DT_TO_LO;
                    end
                end
                ST_DT_TO_LO: begin
                    if (pwm_s_q) begin
                        state_d = ST_HI_ON;
                    end else if (dt_done) begin
                        state_d = ST_LO_ON;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_s_q) begin
                        state_d = ST_DT_TO_HI;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge.
    always_comb begin
        gate_hi_d       = (state_d == ST_HI_ON);
        gate_lo_d       = (state_d == ST_LO_ON);
        dt_active_d     = is_dt_state(state_d);
        fault_latched_d = (state_d == ST_FAULT);
    end

    assign gate_hi       = gate_hi_q;
    assign gate_lo       = gate_lo_q;
    assign dt_active     = dt_active_q;
    assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed and random checks of the dead-time gate driver.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_in = 1'b0;
    logic [3:0] dt_cfg = 4'd3;
    logic       fault = 1'b0;
    logic       fault_clr = 1'b0;
    logic       gate_hi;
    logic       gate_lo;
    logic       dt_active;
    logic       fault_latched;

    int pass_cnt = 0;
    int total_cnt = 0;

    pwm_deadtime #(
        .DTW (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pwm_in        (pwm_in),
        .dt_cfg        (dt_cfg),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .dt_active     (dt_active),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step encoding: [7:4] = {reset, fault, fault_clr, pwm_in} applied before
    // the edge; [3:0] = expected {gate_hi, gate_lo, dt_active, fault_latched} after it.
    task automatic test_reset();
        logic [7:0] steps [9] = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04};
        logic [3:0] got;
        dt_cfg = 4'd3;
        for (int i = 0; i < 9; i++) begin
            {reset, fault, fault_clr, pwm_in} = steps[i][7:4];
            tick();
            got = {gate_hi, gate_lo, dt_active, fault_latched};
            total_cnt++;
            if (got !== steps[i][3:0]) $display("FAIL reset step %0d: got %b expected %b", i, got, steps[i][3:0]);
            else pass_cnt++;
            $display("reset step %0d: hi/lo/dt/flt=%b", i, got);
        end
    endtask

    task automatic test_lo_to_hi();
        logic [7:0] steps [6] = '{8'h14, 8'h12, 8'h12, 8'h12, 8'h18, 8'h18};
        logic [3:0] got;
        dt_cfg = 4'd3;
        for (int i = 0; i < 6; i++) begin
            {reset, fault, fault_clr, pwm_in} = steps[i][7:4];
            tick();
            got = {gate_hi, gate_lo, dt_active, fault_latched};
            total_cnt++;
            if (got !== steps[i][3:0]) $display("FAIL lo_to_hi step %0d: got %b expected %b", i, got, steps[i][3:0]);
            else pass_cnt++;
            $display("lo_to_hi step %0d: hi/lo/dt/flt=%b", i, got);
        end
    endtask

    task automatic test_zero_dt();
        logic [7:0] steps [8] = '{8'h08, 8'h02, 8'h04, 8'h04, 8'h14, 8'h12, 8'h18, 8'h18};
        logic [3:0] got;
        dt_cfg = 4'd0;
        for (int i = 0; i < 8; i++) begin
            {reset, fault, fault_clr, pwm_in} = steps[i][7:4];
            tick();
            got = {gate_hi, gate_lo, dt_active, fault_latched};
            total_cnt++;
            if (got !== steps[i][3:0]) $display("FAIL zero_dt step %0d: got %b expected %b", i, got, steps[i][3:0]);
            else pass_cnt++;
            $display("zero_dt step %0d: hi/lo/dt/flt=%b", i, got);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] steps [14] = '{8'h08, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04,
                                   8'h14, 8'h12, 8'h02, 8'h04, 8'h04, 8'h04};
        logic [3:0] got;
        dt_cfg = 4'd5;
        for (int i = 0; i < 14; i++) begin
            {reset, fault, fault_clr, pwm_in} = steps[i][7:4];
            tick();
            got = {gate_hi, gate_lo, dt_active, fault_latched};
            total_cnt++;
            if (got !== steps[i][3:0]) $display("FAIL glitch step %0d: got %b expected %b", i, got, steps[i][3:0]);
            else pass_cnt++;
            $display("glitch step %0d: hi/lo/dt/flt=%b", i, got);
        end
    endtask

    task automatic test_fault();
        logic [7:0] steps [10] = '{8'h14, 8'h12, 8'h71, 8'h71, 8'h71, 8'h30, 8'h12, 8'h12, 8'h12, 8'h18};
        logic [3:0] got;
        dt_cfg = 4'd3;
        for (int i = 0; i < 10; i++) begin
            {reset, fault, fault_clr, pwm_in} = steps[i][7:4];
            tick();
            got = {gate_hi, gate_lo, dt_active, fault_latched};
            total_cnt++;
            if (got !== steps[i][3:0]) $display("FAIL fault step %0d: got %b expected %b", i, got, steps[i][3:0]);
            else pass_cnt++;
            $display("fault step %0d: hi/lo/dt/flt=%b", i, got);
        end
    endtask

    task automatic test_reset_priority();
        logic [7:0] steps [12] = '{8'h08, 8'h02, 8'hC0, 8'hC0, 8'h41, 8'hC0,
                                   8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h04};
        logic [3:0] got;
        dt_cfg = 4'd4;
        for (int i = 0; i < 12; i++) begin
            {reset, fault, fault_clr, pwm_in} = steps[i][7:4];
            tick();
            got = {gate_hi, gate_lo, dt_active, fault_latched};
            total_cnt++;
            if (got !== steps[i][3:0]) $display("FAIL reset_priority step %0d: got %b expected %b", i, got, steps[i][3:0]);
            else pass_cnt++;
            $display("reset_priority step %0d: hi/lo/dt/flt=%b", i, got);
        end
    endtask

    // Random stress: no overlap ever, and switching to the opposite gate is
    // preceded by at least D cycles with both gates low.
    task automatic test_random();
        int   low_run = 0;
        int   last_on = 0;
        int   d_exp = 1;
        int   turn_ons = 0;
        logic prev_hi = gate_hi;
        logic prev_lo = gate_lo;
        logic prev_dt = dt_active;
        reset = 1'b0;
        fault = 1'b0;
        fault_clr = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) pwm_in = ~pwm_in;
            if ($urandom_range(15) == 0) dt_cfg = 4'($urandom_range(7));
            fault = ($urandom_range(299) == 0) ? 1'b1 : (fault && ($urandom_range(3) != 0));
            fault_clr = ($urandom_range(7) == 0);
            tick();
            total_cnt++;
            if (gate_hi && gate_lo) $display("FAIL random_overlap cycle %0d: got hi=1 lo=1 required not both", i);
            else pass_cnt++;
            if (fault_latched) last_on = 0;
            if (dt_active && !prev_dt) d_exp = (dt_cfg == 4'd0) ? 1 : int'(dt_cfg);
            if (gate_hi && !prev_hi) begin
                if (last_on == 2) begin
                    total_cnt++;
                    turn_ons++;
                    if (low_run < d_exp) $display("FAIL random_hi_deadtime cycle %0d: got %0d low cycles required %0d", i, low_run, d_exp);
                    else pass_cnt++;
                end
                last_on = 1;
            end
            if (gate_lo && !prev_lo) begin
                if (last_on == 1) begin
                    total_cnt++;
                    turn_ons++;
                    if (low_run < d_exp) $display("FAIL random_lo_deadtime cycle %0d: got %0d low cycles required %0d", i, low_run, d_exp);
                    else pass_cnt++;
                end
                last_on = 2;
            end
            low_run = (!gate_hi && !gate_lo) ? low_run + 1 : 0;
            prev_hi = gate_hi;
            prev_lo = gate_lo;
            prev_dt = dt_active;
        end
        $display("random: 10000 cycles, %0d opposite-gate turn-ons checked", turn_ons);
    endtask

    initial begin
        test_reset();
        test_lo_to_hi();
        test_zero_dt();
        test_glitch();
        test_fault();
        test_reset_priority();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL use clock clk and reset reset; reset is synchronous and active-high.
REQ-002 SHALL have parameter DTW, default 4, dead-time counter width in bits.
REQ-003 clk  input  1  rising-edge system clock, same domain as the PWM generator.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 pwm_in  input  1  raw PWM from the generator; 1 = high side requested.
REQ-006 dt_cfg  input  DTW  dead time in clk cycles.
REQ-007 fault  input  1  level fault request; forces both gates off.
REQ-008 fault_clr  input  1  single-cycle request to leave the fault state.
REQ-009 gate_hi  output  1  high-side gate drive, registered.
REQ-010 gate_lo  output  1  low-side gate drive, registered.
REQ-011 dt_active  output  1  1 while a dead-time interval is running, registered.
REQ-012 fault_latched  output  1  1 while in the fault state, registered.

Function
REQ-013 SHALL register pwm_in once into pwm_s; the FSM acts only on pwm_s.
REQ-014 SHALL implement these states: IDLE, DT_TO_HI, HI_ON, DT_TO_LO, LO_ON, FAULT.
REQ-015 Outputs per state SHALL be: HI_ON hi=1/lo=0; LO_ON hi=0/lo=1; all other states hi=0/lo=0.
REQ-016 IDLE SHALL go to DT_TO_HI if pwm_s=1, else to DT_TO_LO, on the next edge.
REQ-017 LO_ON with pwm_s=1 SHALL go to DT_TO_HI; HI_ON with pwm_s=0 SHALL go to DT_TO_LO.
REQ-018 On entering a DT state, the block SHALL load its counter with D = max(dt_cfg,1); dt_cfg is sampled only at entry.
REQ-019 A DT state SHALL last exactly D cycles, then enter its ON state; dt_active=1 for exactly those D cycles.
REQ-020 If pwm_s reverts during DT_TO_HI, the FSM SHALL return to LO_ON on the next edge; the symmetric rule SHALL apply to DT_TO_LO/HI_ON.
REQ-021 Latency: pwm_in toggles before edge N; the conducting gate drops after edge N+1 and the opposite gate rises after edge N+1+D.
REQ-022 gate_hi and gate_lo SHALL never be 1 in the same cycle, under any input sequence.
REQ-023 fault=1 in any state SHALL force FAULT on the next edge; gates go 0 and fault_latched goes 1 on that edge.
REQ-024 FAULT SHALL exit to IDLE only when fault_clr=1 and fault=0 in the same cycle; fault=1 with fault_clr=1 SHALL keep FAULT.
REQ-025 A pwm_in pulse shorter than D cycles SHALL never turn on the opposite gate.

Reset
REQ-026 reset=1 SHALL set state=IDLE, pwm_s=0, counter=0, gate_hi=0, gate_lo=0, dt_active=0, fault_latched=0.
REQ-027 reset SHALL take priority over fault and over all transitions, including in mid-dead-time and in FAULT.
REQ-028 After reset deasserts, the first gate SHALL turn on no earlier than D+2 cycles later.

Structure
REQ-029 A shared package SHALL hold the state enum and the DTW default constant.
REQ-030 The dead-time counter SHALL be one sub-module, pwm_dt_timer: a loadable DTW-bit down-counter with a done flag.
REQ-031 No other hierarchy; total RTL 120-400 lines.

Verification
REQ-032 Bench SHALL cover: reset, then pwm_in=0 and dt_cfg=3 -> lo=0 for 4 cycles after reset release, then lo=1; hi stays 0.
REQ-033 Bench SHALL cover: steady LO_ON, dt_cfg=3, pwm_in 0->1 before edge N -> lo=0 after N+1; hi=1 after N+4; dt_active high exactly 3 cycles.
REQ-034 Bench SHALL cover: dt_cfg=0 -> dead time of exactly 1 cycle both directions; no overlap.
REQ-035 Bench SHALL cover: dt_cfg=5, 2-cycle pwm_in glitch high during LO_ON -> hi never 1; lo returns to 1; dt_active high for 2 cycles.
REQ-036 Bench SHALL cover: fault mid-dead-time with fault_clr held high -> gates 0, fault_latched=1 stays; fault low with fault_clr pulse -> IDLE, then normal dead-time restart.
REQ-037 Bench SHALL cover: random pwm_in, dt_cfg, and fault for 10000 cycles -> assertion that hi and lo are never both 1, and that every gate turn-on is preceded by D cycles with both gates low.
